// File: rtl/msi_cpu_request_sequencer.sv
// Per-line MSI sequencer: holds the line-state array, drives the CPU-request controller,
// and runs bus announce / write-back / refill before committing the new state.
module msi_cpu_request_sequencer #(
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic                  req_tag_match,
  output logic                  cpu_write_hit,
  output logic                  cpu_read_hit,
  output logic                  cpu_write_miss,
  output logic                  cpu_read_miss,
  output logic [1:0]            state_in,
  input  logic [1:0]            ctrl_state_next,
  input  logic                  ctrl_write_back,
  output logic                  bus_valid,
  output logic [1:0]            bus_op,
  output logic                  mem_wb_req,
  input  logic                  mem_wb_ack,
  output logic                  mem_fill_req,
  input  logic                  mem_fill_ack,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            line_state
);

  localparam logic [1:0] ST_INVALID = 2'b00;
  localparam logic [1:0] ST_SHARED  = 2'b10;
  localparam logic [1:0] ST_ERROR   = 2'b11;
  localparam logic [1:0] OP_INVAL   = 2'b00;
  localparam logic [1:0] OP_WMISS   = 2'b01;
  localparam logic [1:0] OP_RMISS   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_BUS, S_WB, S_FILL, S_UPDATE
  } fsm_t;

  fsm_t state, state_nx;

  logic [1:0]            lines [2**INDEX_BITS];
  logic                  lat_write, lat_hit, lat_err, lat_wb;
  logic [INDEX_BITS-1:0] lat_index;
  logic [1:0]            lat_next, lat_op;
  logic [1:0]            cur_state;
  logic                  bus_need;
  logic [1:0]            op_sel;

  assign cur_state = lines[lat_index];
  // A hit needs the bus only to invalidate other sharers on a write.
  assign bus_need  = lat_hit ? (lat_write && (cur_state == ST_SHARED)) : 1'b1;
  assign op_sel    = lat_hit ? OP_INVAL : (lat_write ? OP_WMISS : OP_RMISS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_write <= 1'b0;
      lat_hit   <= 1'b0;
      lat_err   <= 1'b0;
      lat_wb    <= 1'b0;
      lat_index <= '0;
      lat_next  <= ST_INVALID;
      lat_op    <= OP_INVAL;
      for (int i = 0; i < 2**INDEX_BITS; i++) lines[i] <= ST_INVALID;
    end else begin
      state <= state_nx;
      if (req_valid && req_ready) begin
        lat_write <= req_write;
        lat_index <= req_index;
        lat_hit   <= req_tag_match && (lines[req_index] != ST_INVALID);
      end
      if (state == S_LOOKUP) begin
        lat_next <= ctrl_state_next;
        lat_wb   <= ctrl_write_back;
        lat_err  <= (ctrl_state_next == ST_ERROR);
        lat_op   <= op_sel;
      end
      if ((state == S_UPDATE) && !lat_err) lines[lat_index] <= lat_next;
    end
  end

  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    cpu_write_hit  = 1'b0;
    cpu_read_hit   = 1'b0;
    cpu_write_miss = 1'b0;
    cpu_read_miss  = 1'b0;
    state_in       = ST_INVALID;
    bus_valid      = 1'b0;
    bus_op         = OP_INVAL;
    mem_wb_req     = 1'b0;
    mem_fill_req   = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    line_state     = ST_INVALID;
    case (state)
      S_IDLE: begin
        // Held low while reset is asserted so nothing is offered mid-reset.
        req_ready = rst_n;
        if (req_valid && rst_n) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        cpu_write_hit  = lat_write & lat_hit;
        cpu_read_hit   = ~lat_write & lat_hit;
        cpu_write_miss = lat_write & ~lat_hit;
        cpu_read_miss  = ~lat_write & ~lat_hit;
        state_in       = cur_state;
        if (ctrl_state_next == ST_ERROR) state_nx = S_UPDATE;
        else if (bus_need)               state_nx = S_BUS;
        else                             state_nx = S_UPDATE;
      end
      S_BUS: begin
        bus_valid = 1'b1;
        bus_op    = lat_op;
        if (lat_wb)        state_nx = S_WB;
        else if (!lat_hit) state_nx = S_FILL;
        else               state_nx = S_UPDATE;
      end
      S_WB: begin
        mem_wb_req = 1'b1;
        if (mem_wb_ack) state_nx = lat_hit ? S_UPDATE : S_FILL;
      end
      S_FILL: begin
        mem_fill_req = 1'b1;
        if (mem_fill_ack) state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        done       = 1'b1;
        error      = lat_err;
        line_state = lat_err ? ST_ERROR : lat_next;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_msi_cpu_request_sequencer.sv
// Randomized bench for msi_cpu_request_sequencer with a per-request reference model.
module tb_msi_cpu_request_sequencer;
  localparam int IB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_tag_match = 1'b0;
  logic [IB-1:0] req_index = '0;
  logic          cpu_write_hit, cpu_read_hit, cpu_write_miss, cpu_read_miss;
  logic [1:0]    state_in, ctrl_state_next, bus_op, line_state;
  logic          ctrl_write_back, bus_valid, mem_wb_req, mem_wb_ack, mem_fill_req, mem_fill_ack;
  logic          done, error;

  msi_cpu_request_sequencer #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_index(req_index), .req_tag_match(req_tag_match),
    .cpu_write_hit(cpu_write_hit), .cpu_read_hit(cpu_read_hit),
    .cpu_write_miss(cpu_write_miss), .cpu_read_miss(cpu_read_miss),
    .state_in(state_in), .ctrl_state_next(ctrl_state_next), .ctrl_write_back(ctrl_write_back),
    .bus_valid(bus_valid), .bus_op(bus_op), .mem_wb_req(mem_wb_req), .mem_wb_ack(mem_wb_ack),
    .mem_fill_req(mem_fill_req), .mem_fill_ack(mem_fill_ack), .done(done), .error(error),
    .line_state(line_state));

  always #5 clk = ~clk;

  // Environment: a simple MSI controller and memory that acks after a programmable wait.
  logic force_err = 1'b0;
  always_comb begin
    ctrl_state_next = 2'b00;
    if (cpu_write_hit || cpu_write_miss) ctrl_state_next = 2'b01;
    else if (cpu_read_miss)              ctrl_state_next = 2'b10;
    else if (cpu_read_hit)               ctrl_state_next = state_in;
    if (force_err) ctrl_state_next = 2'b11;
    ctrl_write_back = (cpu_write_miss || cpu_read_miss) && (state_in == 2'b01);
  end

  int   wb_dly = 0, fill_dly = 0, wb_cnt = 0, fill_cnt = 0;
  logic wb_force = 1'b0, fill_force = 1'b0;
  always @(posedge clk) begin
    wb_cnt   <= mem_wb_req   ? wb_cnt + 1   : 0;
    fill_cnt <= mem_fill_req ? fill_cnt + 1 : 0;
  end
  assign mem_wb_ack   = (mem_wb_req && (wb_cnt == wb_dly)) || wb_force;
  assign mem_fill_ack = (mem_fill_req && (fill_cnt == fill_dly)) || fill_force;

  logic [1:0] ref_line [2**IB];
  int nvec = 0, nerr = 0;

  task automatic do_req(input logic wr, input logic [IB-1:0] idx, input logic tm,
                        input logic ferr, input int wd, input int fd, input string name);
    logic [1:0] s, exp_ls, exp_op, got_op, got_ls;
    logic [3:0] exp_flags, got_flags;
    logic       hit, miss, need_bus, got_err, rdy_busy;
    int         exp_wb, exp_fill, exp_lat, got_lat, nbus, nwb, nfill, w;
    s        = ref_line[idx];
    hit      = tm && (s != 2'b00);
    miss     = !hit;
    exp_flags = {wr & hit, !wr & hit, wr & miss, !wr & miss};
    exp_op   = miss ? (wr ? 2'b01 : 2'b10) : 2'b00;
    need_bus = !ferr && (miss || (wr && s == 2'b10));
    exp_ls   = ferr ? 2'b11 : (wr ? 2'b01 : (hit ? s : 2'b10));
    exp_wb   = (need_bus && miss && s == 2'b01) ? wd + 1 : 0;
    exp_fill = (need_bus && miss) ? fd + 1 : 0;
    exp_lat  = 2 + (need_bus ? 1 : 0) + exp_wb + exp_fill;
    wb_dly = wd; fill_dly = fd; force_err = ferr;
    got_lat = 0; nbus = 0; nwb = 0; nfill = 0; got_op = 2'b00; got_ls = 2'b00;
    got_err = 1'b0; got_flags = 4'h0; rdy_busy = 1'b0;

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_index = idx; req_tag_match = tm;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    nvec++;
    if (!req_ready) begin
      nerr++; $display("FAIL %s accept: req_ready=%0b required 1", name, req_ready);
      req_valid = 1'b0; force_err = 1'b0; return;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        got_flags = {cpu_write_hit, cpu_read_hit, cpu_write_miss, cpu_read_miss};
        nvec++;
        if (got_flags !== exp_flags || state_in !== s) begin
          nerr++;
          $display("FAIL %s lookup: flags=%b state_in=%b required flags=%b state_in=%b",
                   name, got_flags, state_in, exp_flags, s);
        end
      end
      if (bus_valid) begin nbus++; got_op = bus_op; end
      if (mem_wb_req) nwb++;
      if (mem_fill_req) nfill++;
      if (req_ready) rdy_busy = 1'b1;
      if (done) begin got_lat = k; got_ls = line_state; got_err = error; break; end
    end
    force_err = 1'b0;
    nvec++;
    if (got_lat != exp_lat) begin
      nerr++; $display("FAIL %s latency: got %0d required %0d", name, got_lat, exp_lat);
    end
    nvec++;
    if (got_ls !== exp_ls || got_err !== ferr) begin
      nerr++; $display("FAIL %s result: line_state=%b error=%b required %b/%b",
                       name, got_ls, got_err, exp_ls, ferr);
    end
    nvec++;
    if (nbus != (need_bus ? 1 : 0) || (need_bus && got_op !== exp_op)) begin
      nerr++; $display("FAIL %s bus: count=%0d op=%b required count=%0d op=%b",
                       name, nbus, got_op, need_bus ? 1 : 0, exp_op);
    end
    nvec++;
    if (nwb != exp_wb || nfill != exp_fill) begin
      nerr++; $display("FAIL %s mem: wb=%0d fill=%0d required wb=%0d fill=%0d",
                       name, nwb, nfill, exp_wb, exp_fill);
    end
    nvec++;
    if (rdy_busy !== 1'b0) begin
      nerr++; $display("FAIL %s busy_ready: req_ready=1 while busy required 0", name);
    end
    if (!ferr) ref_line[idx] = exp_ls;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nvec++;
    if ({req_ready, cpu_write_hit, cpu_read_hit, cpu_write_miss, cpu_read_miss, state_in,
         bus_valid, bus_op, mem_wb_req, mem_fill_req, done, error, line_state} !== '0) begin
      nerr++; $display("FAIL reset_outputs: some output nonzero (req_ready=%b done=%b) required all 0",
                       req_ready, done);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
    for (int i = 0; i < 2**IB; i++) ref_line[i] = 2'b00;
  endtask

  task automatic test_directed();
    do_req(1'b0, 4'd3, 1'b0, 1'b0, 0, 0, "read_miss");
    do_req(1'b1, 4'd3, 1'b1, 1'b0, 0, 0, "write_hit_shared");
    do_req(1'b1, 4'd3, 1'b0, 1'b0, 3, 3, "write_miss_dirty");
    do_req(1'b0, 4'd5, 1'b1, 1'b0, 0, 0, "tagmatch_invalid");
    do_req(1'b0, 4'd3, 1'b1, 1'b1, 0, 0, "force_error");
    do_req(1'b0, 4'd3, 1'b1, 1'b0, 0, 0, "after_error_hit");
  endtask

  task automatic test_reset_in_wb();
    int  w;
    logic saw_done;
    do_req(1'b1, 4'd7, 1'b0, 1'b0, 0, 0, "wb_setup");
    wb_dly = 50;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_index = 4'd7; req_tag_match = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    w = 0;
    while (!mem_wb_req && w < 20) begin @(negedge clk); w++; end
    nvec++;
    if (!mem_wb_req) begin
      nerr++; $display("FAIL rst_wb_reach: mem_wb_req=%b required 1", mem_wb_req);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (mem_wb_req !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL rst_wb_drop: mem_wb_req=%b done=%b required 0/0", mem_wb_req, done);
    end
    saw_done = 1'b0;
    repeat (2) begin @(negedge clk); if (done) saw_done = 1'b1; end
    rst_n = 1'b1;
    for (int i = 0; i < 2**IB; i++) ref_line[i] = 2'b00;
    wb_force = 1'b1;
    @(negedge clk); wb_force = 1'b0;
    if (done) saw_done = 1'b1;
    repeat (4) begin @(negedge clk); if (done || mem_wb_req) saw_done = 1'b1; end
    nvec++;
    if (saw_done !== 1'b0 || req_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_wb_late_ack: activity=%b req_ready=%b required 0/1",
                       saw_done, req_ready);
    end
    wb_dly = 0;
    do_req(1'b0, 4'd7, 1'b1, 1'b0, 0, 0, "post_rst_idx7");
    do_req(1'b0, 4'd3, 1'b1, 1'b0, 0, 0, "post_rst_idx3");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_in_wb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/msi_cpu_request_sequencer.md
Name: msi_cpu_request_sequencer

Overview:
- Per-line MSI sequencer wrapped around the CPU-request MSI next-state controller. It is upstream of the controller (drives its hit/miss flags and current state) and downstream of it (consumes its state_next / write_back_block_next).
- Holds the MSI state array, runs the bus-announce / write-back / refill sequence against the memory side, then commits the new line state.
- State encoding: INVALID=00, MODIFIED=01, SHARED=10, 11=error.

Parameters:
INDEX_BITS, 4, line index width; array depth = 2**INDEX_BITS

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  sequencer idle; request accepted when req_valid & req_ready
req_write  input  1  1=write, 0=read
req_index  input  INDEX_BITS  line index
req_tag_match  input  1  tag compare result for req_index
cpu_write_hit, cpu_read_hit, cpu_write_miss, cpu_read_miss  output  1 each  flags to controller
state_in  output  2  current state of latched line, to controller
ctrl_state_next  input  2  controller next state
ctrl_write_back  input  1  controller write-back request
bus_valid  output  1  one-cycle bus announce strobe
bus_op  output  2  00=INVALIDATE, 01=WRITE_MISS, 10=READ_MISS
mem_wb_req  output  1  write-back request, level
mem_wb_ack  input  1  write-back complete
mem_fill_req  output  1  refill request, level
mem_fill_ack  input  1  refill complete
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse with done when the controller returns 11
line_state  output  2  committed state of the request line, valid with done

Behaviour:
- Reset (async, rst_n=0):
  - all array entries INVALID; FSM in IDLE.
  - all outputs 0, except req_ready=1 once rst_n deasserts.
  - An in-flight mem request is dropped with no completion pulse; a late ack after reset is ignored.
- FSM states: IDLE, LOOKUP, BUS, WB, FILL, UPDATE.
- IDLE:
  - req_ready=1.
  - On accept: latch write, index and hit = req_tag_match & (array[index]!=INVALID). A tag match on an INVALID line is a miss.
  - Go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - Assert exactly one cpu_* flag from the latched write/hit; state_in=array[index].
  - Register ctrl_state_next and ctrl_write_back at the clock edge.
  - If ctrl_state_next==11, go to UPDATE with the error flag set.
  - Else go to BUS if a bus op is needed, otherwise UPDATE.
- Bus op needed when:
  - read miss: READ_MISS;
  - write miss: WRITE_MISS;
  - write hit on SHARED: INVALIDATE.
  - Read hit and write hit on MODIFIED need no bus op.
- BUS (1 cycle):
  - bus_valid=1 with bus_op.
  - Next state: WB if the registered write-back bit is set, else FILL if miss, else UPDATE.
- WB:
  - mem_wb_req held high until mem_wb_ack is sampled high; it drops the cycle after.
  - Next state: FILL if miss, else UPDATE.
- FILL:
  - Same handshake on mem_fill_req / mem_fill_ack; then UPDATE.
- Ack sampled while the matching req is low is ignored. No timeout.
- UPDATE (1 cycle):
  - done=1, line_state = registered next state.
  - Write the array entry unless error; with error, the array is unchanged and line_state=11.
  - Return to IDLE; a new request can be accepted next cycle.
- Latency from accept edge to done (0-wait acks):
  - hit without bus op: 2 cycles;
  - write hit on SHARED: 3;
  - clean miss: 4;
  - dirty miss: 5 cycles plus ack wait.
- req_valid outside IDLE is not accepted (req_ready=0); the requester holds it.
- Only the latched index's entry is read or written during a sequence.

Test Plan:
- Reset, read miss idx 3 (INVALID), acks 0-wait -> cpu_read_miss in LOOKUP, bus_op=10, mem_fill_req 1 cycle, no mem_wb_req, done at accept+4, line_state=10.
- Write hit idx 3 (SHARED) -> bus_op=00, no mem traffic, done at accept+3, line_state=01.
- Write miss idx 3 (MODIFIED), acks delayed 3 cycles each -> bus_op=01, mem_wb_req then mem_fill_req each high 4 cycles, done, line_state=01.
- req_tag_match=1 on INVALID idx 5, read -> handled as read miss, line_state=10.
- Force ctrl_state_next=11 -> done and error pulse together, line_state=11, array entry unchanged.
- rst_n low while in WB -> mem_wb_req drops immediately; after reset all lines INVALID, no done pulse, late ack ignored.
